fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the program counter, issues read requests to instruction memory and presents fetched words to decode with a valid/ready handshake.
- Produces pcPlus1, which drives in0 of the next-PC 2:1 multiplexer; the branch target drives in1.
- The multiplexer output returns as nextPc and is loaded when loadPc is high. The multiplexer select is driven by the same branch-taken signal as loadPc.

Parameters:
- addrWidth, 8, width of PC, memAddr, nextPc and pcPlus1.
- dataWidth, 16, width of instruction word (memData, instr).
- resetVector, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- nextPc  input  addrWidth  next-PC multiplexer output.
- loadPc  input  1  redirect strobe; loads nextPc into PC.
- pc  output  addrWidth  current PC register.
- pcPlus1  output  addrWidth  combinational pc+1, modulo 2^addrWidth; feeds multiplexer in0.
- memReq  output  1  read request to instruction memory.
- memAddr  output  addrWidth  read address; equals pc whenever memReq=1.
- memAck  input  1  memory returns valid memData this cycle.
- memData  input  dataWidth  read data.
- instr  output  dataWidth  latched instruction word.
- instrValid  output  1  instr holds a valid word.
- instrReady  input  1  decode accepts instr.
- fetchCount  output  16  accepted-instruction counter (see Optional Feature).

Behaviour:
- Reset values: pc=resetVector, instr=0, instrValid=0, state=FETCH, fetchCount=0.
- memReq is a Moore output: 1 in FETCH, 0 in VALID and FLUSH.
- While reset is high, state is held at FETCH, so memReq=1 with memAddr=resetVector.
- A reset asserted mid-transaction abandons it. Any memAck during reset is ignored.
- State FETCH:
  - On memAck=1 and loadPc=0: instr<=memData, instrValid<=1, pc<=pc+1 (wraps 2^addrWidth-1 to 0), go to VALID.
  - memAck=0 and loadPc=0: hold all state; memReq stays high; wait indefinitely.
- State VALID:
  - instr and instrValid are held stable until accepted.
  - On instrReady=1 and loadPc=0: instrValid<=0, go to FETCH.
  - The next request issues the cycle after acceptance, giving 1 bubble per instruction.
- State FLUSH: one-cycle request gap so memory sees a fresh request. Next state is FETCH unconditionally, unless loadPc is high again (see redirect rules).
- loadPc has priority over every other event in every state.
  - On loadPc=1: pc<=nextPc, instrValid<=0, next state FLUSH.
  - In FETCH with a simultaneous memAck, memData is discarded and instr is unchanged.
  - In VALID with a simultaneous instrReady, the word is dropped and not counted.
  - In FLUSH, pc<=nextPc again and the state stays FLUSH.
- Latency: from memAck to instrValid=1 is 1 cycle. From loadPc to memReq=1 at the new pc is 2 cycles.
- pcPlus1 is purely combinational from pc with no enable. At pc=2^addrWidth-1, pcPlus1=0.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined: fetchCount increments on every cycle with instrValid=1, instrReady=1 and loadPc=0. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: the counter logic is omitted and fetchCount is tied to 16'h0000. The port is always present.

Test Plan:
- Reset sequence: assert reset 2 cycles with resetVector=8'h10, then release. Expect pc=8'h10, pcPlus1=8'h11, memReq=1, memAddr=8'h10, instrValid=0.
- Single fetch: memory acks 1 cycle after request with memData=16'hABCD, instrReady=1. Expect instrValid=1 with instr=16'hABCD for 1 cycle, pc=8'h11, next memAddr=8'h11.
- Backpressure: hold instrReady=0 for 5 cycles after valid. Expect instr stable, memReq=0, pc unchanged. On instrReady=1, fetching resumes the next cycle.
- Redirect collisions:
  - loadPc=1 with nextPc=8'h40 in the same cycle as memAck (memData=16'h1234). Expect instr not updated, instrValid=0, one cycle memReq=0, then memReq=1 with memAddr=8'h40.
  - loadPc=1 with nextPc=8'h50 during VALID with instrReady=1. Expect the word dropped, fetchCount unchanged, then memAddr=8'h50.
- Wrap and counter: start at pc=8'hFF and ack. Expect pc=8'h00 and pcPlus1=8'h01. With FETCH_COUNT_EN, accepting 3 words gives fetchCount=3; without it, fetchCount=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// hands fetched words to decode over a valid/ready handshake. A redirect
// (loadPc) always wins and inserts a one-cycle request gap (FLUSH).
// Optional macro FETCH_COUNT_EN adds a saturating accepted-instruction
// counter; without it fetchCount is tied to zero.
module fetch_unit #(
  parameter int                   addrWidth   = 8,
  parameter int                   dataWidth   = 16,
  parameter logic [addrWidth-1:0] resetVector = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addrWidth-1:0] nextPc,
  input  logic                 loadPc,
  output logic [addrWidth-1:0] pc,
  output logic [addrWidth-1:0] pcPlus1,
  output logic                 memReq,
  output logic [addrWidth-1:0] memAddr,
  input  logic                 memAck,
  input  logic [dataWidth-1:0] memData,
  output logic [dataWidth-1:0] instr,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [15:0]          fetchCount
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [addrWidth-1:0]   r_pc;
  logic [dataWidth-1:0]   r_instr;
  logic                   r_instr_valid;
  logic [addrWidth-1:0]   w_pc_plus1;

  // Incrementer wraps naturally at 2^addrWidth.
  assign w_pc_plus1 = r_pc + addrWidth'(1);

  assign pc         = r_pc;
  assign pcPlus1    = w_pc_plus1;
  assign memAddr    = r_pc;
  assign instr      = r_instr;
  assign instrValid = r_instr_valid;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next-state and Moore request output; loadPc has priority everywhere.
  always_comb begin
    w_state_nxt = r_state;
    memReq      = 1'b0;
    case (r_state)
      FETCH: begin
        memReq = 1'b1;
        if (loadPc)      w_state_nxt = FLUSH;
        else if (memAck) w_state_nxt = VALID;
      end
      VALID: begin
        if (loadPc)          w_state_nxt = FLUSH;
        else if (instrReady) w_state_nxt = FETCH;
      end
      FLUSH: begin
        if (loadPc) w_state_nxt = FLUSH;
        else        w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // PC, instruction latch and valid flag; redirect drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= resetVector;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else if (loadPc) begin
      r_pc          <= nextPc;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (memAck) begin
            r_instr       <= memData;
            r_instr_valid <= 1'b1;
            r_pc          <= w_pc_plus1;
          end
        end
        VALID: begin
          if (instrReady) r_instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  // Count accepted words, saturating; redirected words are not counted.
  always_ff @(posedge clk) begin
    if (reset)
      r_fetch_count <= 16'h0000;
    else if (r_instr_valid && instrReady && !loadPc && (r_fetch_count != 16'hFFFF))
      r_fetch_count <= r_fetch_count + 16'h0001;
  end

  assign fetchCount = r_fetch_count;
`else
  assign fetchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Expected instruction words are queued
// when memory acks them and compared when decode accepts them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  nextPc;
  logic        loadPc;
  logic [7:0]  pc;
  logic [7:0]  pcPlus1;
  logic        memReq;
  logic [7:0]  memAddr;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] fetchCount;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;
  int          accepted = 0;
  logic [15:0] exp_fc;

  fetch_unit #(
    .addrWidth  (8),
    .dataWidth  (16),
    .resetVector(8'h10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nextPc    (nextPc),
    .loadPc    (loadPc),
    .pc        (pc),
    .pcPlus1   (pcPlus1),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memAck    (memAck),
    .memData   (memData),
    .instr     (instr),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .fetchCount(fetchCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counter value the DUT should show for the words accepted so far.
  task automatic calc_fc();
`ifdef FETCH_COUNT_EN
    exp_fc = 16'(accepted);
`else
    exp_fc = 16'h0000;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; loadPc = 1'b0; nextPc = 8'h00; memAck = 1'b0;
    memData = 16'h0000; instrReady = 1'b0;
    step();
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'h10) begin
      n_fail++;
      $display("FAIL reset_hold_req: memReq=%b memAddr=%h, required 1/10", memReq, memAddr);
    end
    reset = 1'b0;
    n_checks++;
    if (pc !== 8'h10 || pcPlus1 !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_pc: pc=%h pcPlus1=%h, required 10/11", pc, pcPlus1);
    end
    n_checks++;
    if (instrValid !== 1'b0 || instr !== 16'h0000 || fetchCount !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outs: instrValid=%b instr=%h fetchCount=%h, required 0/0000/0000",
               instrValid, instr, fetchCount);
    end
  endtask

  task automatic test_single_fetch();
    instrReady = 1'b1;
    step();  // memory waits one cycle
    n_checks++;
    if (memReq !== 1'b1 || pc !== 8'h10 || instrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_wait: memReq=%b pc=%h valid=%b, required 1/10/0", memReq, pc, instrValid);
    end
    memAck = 1'b1; memData = 16'hABCD; exp_q.push_back(16'hABCD);
    step();
    memAck = 1'b0;
    n_checks++;
    if (instrValid !== 1'b1 || pc !== 8'h11 || memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_valid: valid=%b pc=%h memReq=%b, required 1/11/0", instrValid, pc, memReq);
    end
    exp_word = exp_q.pop_front();
    n_checks++;
    if (instr !== exp_word) begin
      n_fail++;
      $display("FAIL fetch_instr: instr=%h, required %h", instr, exp_word);
    end
    accepted++;
    step();
    n_checks++;
    if (instrValid !== 1'b0 || memReq !== 1'b1 || memAddr !== 8'h11) begin
      n_fail++;
      $display("FAIL fetch_next: valid=%b memReq=%b memAddr=%h, required 0/1/11",
               instrValid, memReq, memAddr);
    end
    calc_fc();
    n_checks++;
    if (fetchCount !== exp_fc) begin
      n_fail++;
      $display("FAIL fetch_count1: fetchCount=%h, required %h", fetchCount, exp_fc);
    end
  endtask

  task automatic test_backpressure();
    instrReady = 1'b0;
    memAck = 1'b1; memData = 16'h5A5A; exp_q.push_back(16'h5A5A);
    step();
    memAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (instrValid !== 1'b1 || instr !== exp_q[0] || memReq !== 1'b0 || pc !== 8'h12) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b instr=%h memReq=%b pc=%h, required 1/%h/0/12",
                 i, instrValid, instr, memReq, pc, exp_q[0]);
      end
      step();
    end
    instrReady = 1'b1;
    exp_word = exp_q.pop_front();
    n_checks++;
    if (instr !== exp_word || instrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_instr: instr=%h valid=%b, required %h/1", instr, instrValid, exp_word);
    end
    accepted++;
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'h12 || instrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_resume: memReq=%b memAddr=%h valid=%b, required 1/12/0",
               memReq, memAddr, instrValid);
    end
  endtask

  task automatic test_redirect_ack();
    memAck = 1'b1; memData = 16'h1234; loadPc = 1'b1; nextPc = 8'h40;
    step();
    memAck = 1'b0; loadPc = 1'b0;
    n_checks++;
    if (instrValid !== 1'b0 || instr !== 16'h5A5A || memReq !== 1'b0 || pc !== 8'h40) begin
      n_fail++;
      $display("FAIL redir_ack: valid=%b instr=%h memReq=%b pc=%h, required 0/5a5a/0/40",
               instrValid, instr, memReq, pc);
    end
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'h40) begin
      n_fail++;
      $display("FAIL redir_ack_req: memReq=%b memAddr=%h, required 1/40", memReq, memAddr);
    end
  endtask

  task automatic test_redirect_valid();
    instrReady = 1'b0; memAck = 1'b1; memData = 16'h7777;
    step();
    memAck = 1'b0;
    n_checks++;
    if (instrValid !== 1'b1 || instr !== 16'h7777 || pc !== 8'h41) begin
      n_fail++;
      $display("FAIL redir_v_setup: valid=%b instr=%h pc=%h, required 1/7777/41", instrValid, instr, pc);
    end
    instrReady = 1'b1; loadPc = 1'b1; nextPc = 8'h50;
    step();
    loadPc = 1'b0;
    calc_fc();
    n_checks++;
    if (instrValid !== 1'b0 || fetchCount !== exp_fc || memReq !== 1'b0 || pc !== 8'h50) begin
      n_fail++;
      $display("FAIL redir_valid: valid=%b fetchCount=%h memReq=%b pc=%h, required 0/%h/0/50",
               instrValid, fetchCount, memReq, pc, exp_fc);
    end
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'h50) begin
      n_fail++;
      $display("FAIL redir_v_req: memReq=%b memAddr=%h, required 1/50", memReq, memAddr);
    end
  endtask

  task automatic test_wrap_and_count();
    loadPc = 1'b1; nextPc = 8'h80;
    step();   // enters FLUSH
    nextPc = 8'hFF;
    step();   // redirect again while in FLUSH
    loadPc = 1'b0;
    n_checks++;
    if (memReq !== 1'b0 || pc !== 8'hFF || pcPlus1 !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_redir: memReq=%b pc=%h pcPlus1=%h, required 0/ff/00", memReq, pc, pcPlus1);
    end
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_req: memReq=%b memAddr=%h, required 1/ff", memReq, memAddr);
    end
    instrReady = 1'b0; memAck = 1'b1; memData = 16'hBEEF; exp_q.push_back(16'hBEEF);
    step();
    memAck = 1'b0;
    n_checks++;
    if (pc !== 8'h00 || pcPlus1 !== 8'h01 || instrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h pcPlus1=%h valid=%b, required 00/01/1", pc, pcPlus1, instrValid);
    end
    instrReady = 1'b1;
    exp_word = exp_q.pop_front();
    n_checks++;
    if (instr !== exp_word) begin
      n_fail++;
      $display("FAIL wrap_instr: instr=%h, required %h", instr, exp_word);
    end
    accepted++;
    step();
    calc_fc();
    n_checks++;
    if (fetchCount !== exp_fc) begin
      n_fail++;
      $display("FAIL count3: fetchCount=%h, required %h", fetchCount, exp_fc);
    end
  endtask

  task automatic test_reset_mid();
    instrReady = 1'b0; memAck = 1'b1; memData = 16'hC0DE;
    step();   // now VALID holding C0DE
    reset = 1'b1; memAck = 1'b1; memData = 16'hDEAD;
    step();
    step();
    n_checks++;
    if (instrValid !== 1'b0 || instr !== 16'h0000 || pc !== 8'h10 || memReq !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b instr=%h pc=%h memReq=%b, required 0/0000/10/1",
               instrValid, instr, pc, memReq);
    end
    n_checks++;
    if (fetchCount !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_count: fetchCount=%h, required 0000", fetchCount);
    end
    reset = 1'b0; memAck = 1'b0; exp_q.delete(); accepted = 0;
    step();
    n_checks++;
    if (memReq !== 1'b1 || memAddr !== 8'h10 || instrValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: memReq=%b memAddr=%h valid=%b, required 1/10/0",
               memReq, memAddr, instrValid);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_redirect_ack();
    test_redirect_valid();
    test_wrap_and_count();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
